// File: rtl/sqr6_pkg.sv
// Shared widths and state encoding for the sum-of-squares frame accumulator.
package sqr6_pkg;

  localparam int unsigned SQ_W      = 12;
  localparam int unsigned ACC_W_DEF = 18;
  localparam int unsigned CNT_W     = 7;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

endpackage

// File: rtl/sqr6_frame_acc.sv
// Accumulates squarer results into frames of FRAME_LEN samples (or fewer on
// flush) and presents the frame sum and sample count over a valid/ready port.
module sqr6_frame_acc
  import sqr6_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SQ_W-1:0]  sq_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             err_bit1
);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_sum_q;
  logic [CNT_W-1:0]   out_cnt_q;
  logic               err_q;
  logic               bubble_q;
  logic               accept;
  logic               frame_full;

  // bubble_q holds off input for the one cycle after a result handoff
  assign in_ready  = (state_q == ACC) && !bubble_q;
  assign out_valid = (state_q == OUT);
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign err_bit1  = err_q;

  always_comb begin
    accept     = in_valid && in_ready;
    acc_d      = acc_q + ACC_W'(sq_in);
    cnt_d      = cnt_q + 1'b1;
    frame_full = accept && (cnt_d == CNT_W'(FRAME_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      bubble_q  <= 1'b0;
    end else begin
      bubble_q <= 1'b0;
      if (accept && sq_in[1]) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ACC: begin
          if (accept) begin
            if (frame_full || flush) begin
              out_sum_q <= acc_d;
              out_cnt_q <= cnt_d;
              state_q   <= OUT;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
            end
          end else if (flush && (cnt_q != '0)) begin
            out_sum_q <= acc_q;
            out_cnt_q <= cnt_q;
            state_q   <= OUT;
          end
        end
        OUT: begin
          // partial accumulator is cleared at handoff, not at frame close
          if (out_ready) begin
            state_q  <= ACC;
            acc_q    <= '0;
            cnt_q    <= '0;
            bubble_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqr6_frame_acc.sv
// Self-checking bench for sqr6_frame_acc: directed scenarios plus a random run,
// compared against a transaction-level frame model.
module tb_sqr6_frame_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] sq_in;
  logic        flush;
  logic        out_ready;

  logic        ir16, ov16, err16;
  logic [17:0] sum16;
  logic [6:0]  cnt16;
  logic        ir64, ov64, err64;
  logic [17:0] sum64;
  logic [6:0]  cnt64;

  logic        sel64 = 1'b0;
  logic        ir, ov, errb;
  logic [17:0] osum;
  logic [6:0]  ocnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqr6_frame_acc #(.FRAME_LEN(16), .ACC_W(18)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .sq_in(sq_in),
    .flush(flush), .out_valid(ov16), .out_ready(out_ready), .out_sum(sum16),
    .out_cnt(cnt16), .err_bit1(err16)
  );

  sqr6_frame_acc #(.FRAME_LEN(64), .ACC_W(18)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .sq_in(sq_in),
    .flush(flush), .out_valid(ov64), .out_ready(out_ready), .out_sum(sum64),
    .out_cnt(cnt64), .err_bit1(err64)
  );

  assign ir   = sel64 ? ir64  : ir16;
  assign ov   = sel64 ? ov64  : ov16;
  assign errb = sel64 ? err64 : err16;
  assign osum = sel64 ? sum64 : sum16;
  assign ocnt = sel64 ? cnt64 : cnt16;

  // Frame model: 0 = collecting, 1 = presenting result, 2 = handoff bubble
  int          m_mode;
  int          m_fl;
  int          m_q[$];
  int          m_sum;
  int          m_cnt;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit iv, input logic [11:0] sq, input bit fl, input bit ordy);
    int s;
    bit took;
    took = 1'b0;
    case (m_mode)
      0: begin
        if (iv) begin
          m_q.push_back(int'(sq));
          took = 1'b1;
          if (sq[1]) m_err = 1'b1;
        end
        if ((took && m_q.size() == m_fl) || (fl && m_q.size() > 0)) begin
          s = 0;
          foreach (m_q[k]) s += m_q[k];
          m_sum = s;
          m_cnt = m_q.size();
          m_q.delete();
          m_mode = 1;
        end
      end
      1: if (ordy) m_mode = 2;
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("in_ready",  32'(ir),   32'(m_mode == 0));
    chk("out_valid", 32'(ov),   32'(m_mode == 1));
    chk("out_sum",   32'(osum), 32'(m_sum));
    chk("out_cnt",   32'(ocnt), 32'(m_cnt));
    chk("err_bit1",  32'(errb), 32'(m_err));
  endtask

  // Called at edge+1: check current outputs, drive inputs, advance one clock.
  task automatic cyc(input bit iv, input logic [11:0] sq, input bit fl, input bit ordy);
    check_outputs();
    in_valid  = iv;
    sq_in     = sq;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    model_step(iv, sq, fl, ordy);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    model_reset();
  endtask

  initial begin
    int lows;
    int r;
    logic [11:0] v;
    rst = 1'b0; in_valid = 1'b0; sq_in = '0; flush = 1'b0; out_ready = 1'b1;
    m_fl = 16;
    model_reset();
    @(posedge clk);
    #1;

    do_reset();
    cyc(1'b0, 12'h0, 1'b0, 1'b1);

    // Full frame of max squares, handoff timing
    for (int i = 0; i < 16; i++) cyc(1'b1, 12'hF81, 1'b0, 1'b1);
    chk("full_valid", 32'(ov), 32'd1);
    chk("full_sum", 32'(osum), 32'd63504);
    chk("full_cnt", 32'(ocnt), 32'd16);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      if (!ir) lows++;
      cyc(1'b0, 12'h0, 1'b0, 1'b1);
    end
    chk("ready_low_cycles", 32'(lows), 32'd2);

    // Flush with a beat in the same cycle; flush on an empty frame
    cyc(1'b1, 12'd1, 1'b0, 1'b1);
    cyc(1'b1, 12'd4, 1'b0, 1'b1);
    cyc(1'b1, 12'd9, 1'b1, 1'b1);
    chk("flush_sum", 32'(osum), 32'd14);
    chk("flush_cnt", 32'(ocnt), 32'd3);
    cyc(1'b0, 12'h0, 1'b1, 1'b1);
    cyc(1'b0, 12'h0, 1'b1, 1'b1);
    cyc(1'b0, 12'h0, 1'b1, 1'b1);
    cyc(1'b0, 12'h0, 1'b1, 1'b1);
    chk("empty_flush_valid", 32'(ov), 32'd0);

    // Back-pressure on the result port
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 63);
      v = 12'(r * r);
      cyc(1'b1, v, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 32'(ir), 32'd0);
      cyc(1'b1, 12'd36, 1'b0, 1'b0);
    end
    cyc(1'b1, 12'd36, 1'b0, 1'b1);
    cyc(1'b1, 12'd36, 1'b0, 1'b1);
    cyc(1'b1, 12'd25, 1'b1, 1'b1);
    chk("restart_sum", 32'(osum), 32'd25);
    chk("restart_cnt", 32'(ocnt), 32'd1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);

    // Impossible-square flag is sticky across frames
    cyc(1'b1, 12'h002, 1'b0, 1'b1);
    cyc(1'b1, 12'd49, 1'b1, 1'b1);
    chk("err_sum", 32'(osum), 32'd51);
    chk("err_set", 32'(errb), 32'd1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);
    cyc(1'b1, 12'd16, 1'b1, 1'b1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);
    chk("err_sticky", 32'(errb), 32'd1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial frame and clears the flag
    for (int i = 0; i < 7; i++) cyc(1'b1, 12'd100, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 12'd1, 1'b0, 1'b1);
    chk("post_rst_sum", 32'(osum), 32'd16);
    chk("post_rst_cnt", 32'(ocnt), 32'd16);
    chk("post_rst_err", 32'(errb), 32'd0);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 63);
        v = ($urandom_range(0, 19) == 0) ? 12'($urandom) : 12'(r * r);
        cyc(1'($urandom_range(0, 3) != 0), v, ($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)));
      end
    end

    // 64-sample frame of max squares
    sel64 = 1'b1;
    m_fl  = 64;
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, 12'hF81, 1'b0, 1'b1);
    chk("f64_valid", 32'(ov), 32'd1);
    chk("f64_sum", 32'(osum), 32'd254016);
    chk("f64_cnt", 32'(ocnt), 32'd64);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sqr6_frame_acc.md
SQR6_FRAME_ACC -- requirements
Module: sqr6_frame_acc

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning samples per frame; legal range 1..64.
REQ-002 SHALL have parameter ACC_W, default 18, meaning accumulator/result width; sized so 64 x 3969 = 254016 fits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream squarer result valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port sq_in  input  12  square of a 6-bit operand; sq_in[11] = squarer bit z00 (MSB) ... sq_in[0] = z11 (LSB).
REQ-008 SHALL have port flush  input  1  close the current frame early.
REQ-009 SHALL have port out_valid  output  1  frame result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_sum  output  ACC_W  sum of squares of the frame.
REQ-012 SHALL have port out_cnt  output  7  number of samples in the frame (1..64).
REQ-013 SHALL have port err_bit1  output  1  sticky flag: an accepted sample had sq_in[1]=1 (impossible for a true square).

Function
REQ-014 SHALL implement two states: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
REQ-015 Accept = in_valid & in_ready; on accept, acc <= acc + zero-extended sq_in and cnt <= cnt + 1.
REQ-016 SHALL be unsigned, no saturation; ACC_W guarantees no overflow for FRAME_LEN <= 64.
REQ-017 ACC->OUT when an accept brings cnt to FRAME_LEN; out_valid asserts the next cycle (latency 1 from last accepted beat).
REQ-018 ACC->OUT when flush=1 and (cnt > 0 or an accept occurs that cycle); a beat accepted in the flush cycle is included in the frame.
REQ-019 flush in ACC with cnt=0 and no accept SHALL be ignored; flush in OUT SHALL be ignored.
REQ-020 In OUT, out_sum and out_cnt SHALL hold stable until out_valid & out_ready.
REQ-021 On out_valid & out_ready: next cycle state=ACC, acc=0, cnt=0; no sample accepted during the handoff cycle (one bubble).
REQ-022 in_valid while in OUT SHALL be back-pressured (not accepted, not lost upstream).
REQ-023 err_bit1 SHALL set on any accept with sq_in[1]=1; the sample is still summed; cleared only by reset.
REQ-024 out_sum/out_cnt SHALL be driven from registers (no combinational path from sq_in).

Reset
REQ-025 rst=1 at a clock edge SHALL force state=ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_cnt=0, err_bit1=0; in_ready=1 from the first cycle after rst deasserts.
REQ-026 rst mid-frame or during OUT SHALL discard the partial frame/pending result; rst has priority over every other event in the same cycle.

Structure
REQ-027 Shared package sqr6_pkg SHALL hold SQ_W=12, ACC_W default, CNT_W=7, and the state enum {ACC, OUT}.
REQ-028 SHALL be a single flat module, no sub-modules; the combinational squarer is instantiated outside, feeding sq_in.

Verification
REQ-029 FRAME_LEN=16, 16 back-to-back beats of 3969 (0xF81), out_ready=1 -> out_sum=63504, out_cnt=16, out_valid one cycle after beat 16, in_ready low exactly 2 cycles.
REQ-030 Beats 1, 4, 9 with flush on the 9 beat -> next cycle out_sum=14, out_cnt=3; flush asserted with cnt=0 -> no out_valid.
REQ-031 Frame complete, out_ready=0 for 5 cycles -> out_valid, out_sum, out_cnt stable, in_ready=0, held in_valid not accepted; out_ready=1 -> ACC, next frame starts at 0.
REQ-032 Beat sq_in=0x002 -> err_bit1=1 and remains 1 across later frames; frame sum includes 2.
REQ-033 rst after 7 of 16 beats, then 16 beats of 1 -> out_sum=16, out_cnt=16, err_bit1=0.
REQ-034 FRAME_LEN=64, 64 beats of 3969 -> out_sum=254016, out_cnt=64, no overflow.
